cdp_dp_mul_ctrl: RTL and testbench

Per-layer sequencer for the CDP multiplier stage. It latches the bypass and beat-count configuration at layer start and joins the square-sum stream (sync) with the interpolation stream (intp) into one issue handshake. It limits in-flight beats with a credit counter, drains the multiplier pipeline, and pulses done. It sits between the LUT/interp and sync-FIFO outputs and the multiplier lanes, and feeds the multiplier's bypass select.

---
 rtl/cdp_mul_ctrl_pkg.sv | 15 +
 rtl/cdp_credit_cnt.sv | 41 ++++
 rtl/cdp_dp_mul_ctrl.sv | 117 +++++++++++
 tb/tb_cdp_dp_mul_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdp_mul_ctrl_pkg.sv
// rtl/cdp_mul_ctrl_pkg.sv - shared types and defaults for the CDP multiplier sequencer
package cdp_mul_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } mul_state_e;

  localparam int CNT_W_DEF    = 32;
  localparam int OUTS_W_DEF   = 4;
  localparam int MAX_OUTS_DEF = 8;

endpackage

// File: rtl/cdp_credit_cnt.sv
// rtl/cdp_credit_cnt.sv - outstanding-beat up/down counter, saturating at zero, with full flag
module cdp_credit_cnt #(
  parameter int OUTS_W   = 4,
  parameter int MAX_OUTS = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [OUTS_W-1:0] count_o,
  output logic              full_o
);

  localparam logic [OUTS_W-1:0] MAX_CNT = OUTS_W'(MAX_OUTS);

  logic [OUTS_W-1:0] count_q, count_d;
  logic              dec_eff;

  // A retire with nothing outstanding is dropped so the count never underflows.
  always_comb begin
    dec_eff = dec_i & (count_q != '0);
    count_d = count_q;
    if (inc_i && !dec_eff) begin
      count_d = count_q + OUTS_W'(1);
    end else if (dec_eff && !inc_i) begin
      count_d = count_q - OUTS_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  assign full_o  = (count_q >= MAX_CNT);

endmodule

// File: rtl/cdp_dp_mul_ctrl.sv
// rtl/cdp_dp_mul_ctrl.sv - per-layer sequencer joining sync/intp streams into the multiplier issue port
module cdp_dp_mul_ctrl
  import cdp_mul_ctrl_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int OUTS_W   = OUTS_W_DEF,
  parameter int MAX_OUTS = MAX_OUTS_DEF
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             reg2dp_op_en,
  input  logic             reg2dp_mul_bypass,
  input  logic [CNT_W-1:0] reg2dp_beat_cnt,
  input  logic             sync_pvld,
  output logic             sync_prdy,
  input  logic             intp_pvld,
  output logic             intp_prdy,
  output logic             issue_vld,
  input  logic             issue_rdy,
  output logic             mul_bypass_en,
  input  logic             out_fire,
  output logic             busy,
  output logic             dp2reg_done
);

  mul_state_e        state_q, state_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  beat_q, beat_d;
  logic              byp_q, byp_d;
  logic              busy_q, busy_d;
  logic              armed_q, armed_d;
  logic [OUTS_W-1:0] outs;
  logic              full, run, can_issue, fire;

  // A retire in the same cycle frees the slot the new beat takes.
  assign run       = (state_q == RUN);
  assign can_issue = ~full | out_fire;
  assign issue_vld = run & sync_pvld & intp_pvld & can_issue;
  assign sync_prdy = run & issue_rdy & intp_pvld & can_issue;
  assign intp_prdy = run & issue_rdy & sync_pvld & can_issue;
  assign fire      = issue_vld & issue_rdy;

  cdp_credit_cnt #(
    .OUTS_W   (OUTS_W),
    .MAX_OUTS (MAX_OUTS)
  ) u_credit (
    .clk_i   (nvdla_core_clk),
    .rst_ni  (nvdla_core_rstn),
    .inc_i   (fire),
    .dec_i   (out_fire),
    .count_o (outs),
    .full_o  (full)
  );

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    beat_d  = beat_q;
    byp_d   = byp_q;
    busy_d  = busy_q;
    armed_d = armed_q | ~reg2dp_op_en;
    case (state_q)
      IDLE: begin
        if (reg2dp_op_en && armed_q) begin
          byp_d   = reg2dp_mul_bypass;
          total_d = reg2dp_beat_cnt;
          beat_d  = '0;
          busy_d  = 1'b1;
          state_d = (reg2dp_beat_cnt == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (fire) begin
          beat_d = beat_q + CNT_W'(1);
          if (beat_q == total_q - CNT_W'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (outs == '0) begin
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        armed_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // armed_q comes out of reset set: no layer has completed yet, so op_en need not be seen low first.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= IDLE;
      total_q <= '0;
      beat_q  <= '0;
      byp_q   <= 1'b0;
      busy_q  <= 1'b0;
      armed_q <= 1'b1;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      beat_q  <= beat_d;
      byp_q   <= byp_d;
      busy_q  <= busy_d;
      armed_q <= armed_d;
    end
  end

  assign mul_bypass_en = byp_q;
  assign busy          = busy_q;
  assign dp2reg_done   = (state_q == DONE);

endmodule

// File: tb/tb_cdp_dp_mul_ctrl.sv
// tb/tb_cdp_dp_mul_ctrl.sv - self-checking bench for cdp_dp_mul_ctrl against a beat-level reference model
module tb_cdp_dp_mul_ctrl;

  localparam int MAXO = 8;

  logic        clk, rst_n;
  logic        reg2dp_op_en, reg2dp_mul_bypass;
  logic [31:0] reg2dp_beat_cnt;
  logic        sync_pvld, sync_prdy, intp_pvld, intp_prdy;
  logic        issue_vld, issue_rdy, mul_bypass_en, out_fire, busy, dp2reg_done;

  cdp_dp_mul_ctrl #(.CNT_W(32), .OUTS_W(4), .MAX_OUTS(MAXO)) dut (
    .nvdla_core_clk    (clk),
    .nvdla_core_rstn   (rst_n),
    .reg2dp_op_en      (reg2dp_op_en),
    .reg2dp_mul_bypass (reg2dp_mul_bypass),
    .reg2dp_beat_cnt   (reg2dp_beat_cnt),
    .sync_pvld         (sync_pvld),
    .sync_prdy         (sync_prdy),
    .intp_pvld         (intp_pvld),
    .intp_prdy         (intp_prdy),
    .issue_vld         (issue_vld),
    .issue_rdy         (issue_rdy),
    .mul_bypass_en     (mul_bypass_en),
    .out_fire          (out_fire),
    .busy              (busy),
    .dp2reg_done       (dp2reg_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests, fails;
  int cyc;
  // Reference model: a layer is a count of beats to issue, a population of beats in flight,
  // and a countdown to the done pulse (-1 when none is pending).
  bit m_busy, m_byp, m_armed;
  int m_total, m_fires, m_outs, m_cd;
  int retire_q[$];
  int dly;
  bit hold_ofire, force_one, spur_en, hold_op;
  bit saw_done;
  int done_cyc, op_cyc, last_ofire_cyc, first_fire_cyc, last_fire_cyc;
  int dut_fires, bad_fire, bad_sprdy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_byp = 0; m_armed = 1;
    m_total = 0; m_fires = 0; m_outs = 0; m_cd = -1;
    retire_q.delete();
  endtask

  task automatic tick();
    bit run, can, e_vld, e_sp, e_ip, fire, dec, finishing;
    if (force_one) out_fire = 1'b1;
    else if (!hold_ofire && retire_q.size() > 0 && retire_q[0] <= cyc) out_fire = 1'b1;
    else if (spur_en && retire_q.size() == 0 && m_outs == 0 && $urandom_range(0, 3) == 0) out_fire = 1'b1;
    else out_fire = 1'b0;
    @(negedge clk);
    run   = m_busy && (m_fires < m_total) && (m_cd < 0);
    can   = (m_outs < MAXO) || out_fire;
    e_vld = run && sync_pvld && intp_pvld && can;
    e_sp  = run && issue_rdy && intp_pvld && can;
    e_ip  = run && issue_rdy && sync_pvld && can;
    chk("issue_vld", issue_vld, e_vld);
    chk("sync_prdy", sync_prdy, e_sp);
    chk("intp_prdy", intp_prdy, e_ip);
    chk("busy", busy, m_busy);
    chk("dp2reg_done", dp2reg_done, (m_cd == 0));
    chk("mul_bypass_en", mul_bypass_en, m_byp);
    if (issue_vld && issue_rdy) begin
      if (dut_fires == 0) first_fire_cyc = cyc;
      last_fire_cyc = cyc;
      dut_fires++;
      if (!intp_pvld) bad_fire++;
    end
    if (sync_prdy && !intp_pvld) bad_sprdy++;
    if (dp2reg_done) begin saw_done = 1; done_cyc = cyc; end
    @(posedge clk);
    fire = e_vld && issue_rdy;
    if (!rst_n) begin
      model_reset();
    end else begin
      finishing = (m_cd == 0);
      if (finishing) begin
        m_busy = 0; m_cd = -1;
      end else if (m_busy && m_fires == m_total && m_cd < 0 && m_outs == 0) begin
        m_cd = 0;
      end else if (!m_busy && reg2dp_op_en && m_armed) begin
        m_busy = 1; m_byp = reg2dp_mul_bypass; m_total = int'(reg2dp_beat_cnt);
        m_fires = 0; op_cyc = cyc;
        if (m_total == 0) m_cd = 0;
      end
      dec = out_fire && m_outs > 0;
      if (dec) begin void'(retire_q.pop_front()); last_ofire_cyc = cyc; end
      if (fire) begin m_fires++; retire_q.push_back(cyc + dly); end
      m_outs = m_outs + int'(fire) - int'(dec);
      if (finishing) m_armed = 0;
      else if (!reg2dp_op_en) m_armed = 1;
    end
    cyc++;
    #1;
  endtask

  task automatic set_streams(input int mode);
    case (mode)
      0: begin sync_pvld = 1; intp_pvld = 1; issue_rdy = 1; dly = 3; end
      1: begin sync_pvld = 1; intp_pvld = cyc[0]; issue_rdy = 1; dly = $urandom_range(1, 3); end
      default: begin
        sync_pvld = ($urandom_range(0, 3) != 0);
        intp_pvld = ($urandom_range(0, 3) != 0);
        issue_rdy = ($urandom_range(0, 3) != 0);
        dly = $urandom_range(0, 5);
        reg2dp_mul_bypass = $urandom_range(0, 1);
        reg2dp_beat_cnt = $urandom_range(0, 20);
      end
    endcase
  endtask

  task automatic start_layer(input int cnt, input bit byp, input int mode);
    saw_done = 0; dut_fires = 0; bad_fire = 0; bad_sprdy = 0;
    reg2dp_beat_cnt = cnt; reg2dp_mul_bypass = byp; reg2dp_op_en = 1;
    set_streams(mode);
    reg2dp_beat_cnt = cnt; reg2dp_mul_bypass = byp;
    tick();
    if (!hold_op) reg2dp_op_en = 0;
  endtask

  task automatic wait_done(input int mode, input string tag);
    for (int k = 0; k < 300 && !saw_done; k++) begin
      set_streams(mode);
      tick();
    end
    chk(tag, saw_done, 1'b1);
    reg2dp_op_en = 0;
    tick();
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    hold_ofire = 0; force_one = 0; spur_en = 0; hold_op = 0;
    dly = 3; done_cyc = -1; op_cyc = 0; last_ofire_cyc = -1;
    first_fire_cyc = -1; last_fire_cyc = -1;
    dut_fires = 0; bad_fire = 0; bad_sprdy = 0; saw_done = 0;
    model_reset();
    rst_n = 0; reg2dp_op_en = 0; reg2dp_mul_bypass = 1; reg2dp_beat_cnt = 5;
    sync_pvld = 1; intp_pvld = 1; issue_rdy = 1; out_fire = 0;
    repeat (3) tick();
    rst_n = 1;
    tick();

    // Four beats, free-flowing streams, retire three cycles after issue.
    start_layer(4, 0, 0);
    wait_done(0, "t1_timeout");
    chk("t1_fires", dut_fires, 4);
    chk("t1_first_fire", first_fire_cyc, op_cyc + 1);
    chk("t1_consecutive", last_fire_cyc - first_fire_cyc, 3);
    chk("t1_done_after_retire", done_cyc, last_ofire_cyc + 2);

    // Empty layer: no issue, done on the cycle after op_en is sampled.
    start_layer(0, 0, 0);
    wait_done(0, "t2_timeout");
    chk("t2_fires", dut_fires, 0);
    chk("t2_done_cyc", done_cyc, op_cyc + 1);

    // Interp stream valid only on alternate cycles.
    start_layer(3, 0, 1);
    wait_done(1, "t3_timeout");
    chk("t3_fires", dut_fires, 3);
    chk("t3_fire_on_intp", bad_fire, 0);
    chk("t3_sprdy_gated", bad_sprdy, 0);

    // Credit limit: nothing retires, issue stalls at MAXO, one retire admits one more.
    hold_ofire = 1;
    start_layer(10, 0, 0);
    for (int k = 0; k < 15; k++) begin set_streams(0); tick(); end
    chk("t4_stall_fires", dut_fires, MAXO);
    chk("t4_stalled_vld", issue_vld, 1'b0);
    force_one = 1;
    tick();
    force_one = 0;
    chk("t4_credit_fire", dut_fires, MAXO + 1);
    hold_ofire = 0;
    wait_done(0, "t4_timeout");
    chk("t4_fires", dut_fires, 10);

    // Bypass latched at start; register flip mid-layer ignored.
    start_layer(6, 1, 0);
    reg2dp_mul_bypass = 0;
    reg2dp_beat_cnt = 1;
    wait_done(0, "t5_timeout");
    chk("t5_fires", dut_fires, 6);
    chk("t5_bypass_kept", mul_bypass_en, 1'b1);

    // Reset after two of five beats, then a full layer.
    start_layer(5, 1, 0);
    for (int k = 0; k < 20 && dut_fires < 2; k++) begin set_streams(0); tick(); end
    chk("t6_pre_fires", dut_fires, 2);
    rst_n = 0;
    #1;
    chk("t6_rst_vld", issue_vld, 1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_byp", mul_bypass_en, 1'b0);
    chk("t6_rst_done", dp2reg_done, 1'b0);
    model_reset();
    repeat (2) tick();
    rst_n = 1;
    tick();
    chk("t6_no_done", saw_done, 1'b0);
    start_layer(5, 0, 0);
    wait_done(0, "t6_timeout");
    chk("t6_fires", dut_fires, 5);

    // Random layers with random handshakes, retire delays, spurious retires and held op_en.
    spur_en = 1;
    for (int i = 0; i < 8; i++) begin
      int cnt;
      cnt = $urandom_range(0, 12);
      hold_op = $urandom_range(0, 1);
      start_layer(cnt, $urandom_range(0, 1), 2);
      for (int k = 0; k < 400 && !saw_done; k++) begin
        set_streams(2);
        tick();
      end
      chk("rnd_timeout", saw_done, 1'b1);
      chk("rnd_fires", dut_fires, cnt);
      tick();
      tick();
      reg2dp_op_en = 0;
      hold_op = 0;
      tick();
    end
    spur_en = 0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
